axis_block_detector: RTL and testbench

- Produces the per-channel AXI-Stream block flags that the deadlock-idx monitors consume.
- Watches the TVALID/TREADY pair of each stream port on the dataflow kernel (the dds_ddc_center stream interfaces).
- Asserts a registered block flag once a port has stalled for a programmable number of consecutive cycles.
- Keeps per-channel peak-stall statistics for debug readout.

---
 rtl/axis_block_detector_pkg.sv | 22 ++
 rtl/axis_block_channel.sv | 82 ++++++++
 rtl/axis_block_detector.sv | 48 ++++
 tb/tb_axis_block_detector.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/axis_block_detector_pkg.sv
// Shared types and helpers for the AXI-Stream block detector slice.
// Holds the channel state encoding, stall-direction constants and the saturating increment.
package axis_block_pkg;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    BLOCKED
  } state_t;

  localparam logic DIR_PRODUCER = 1'b1;
  localparam logic DIR_CONSUMER = 1'b0;

  localparam int SAT_W = 32;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [SAT_W-1:0] saturating_inc(input logic [SAT_W-1:0] cnt,
                                                      input logic [SAT_W-1:0] max_val);
    return (cnt >= max_val) ? max_val : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/axis_block_channel.sv
// One monitored AXI-Stream port: stall FSM, consecutive-stall counter and peak register.
// Exposes both the registered block flag and its next-state value for the top-level OR.
module axis_block_channel
  import axis_block_pkg::*;
#(
  parameter int   CNT_W        = 16,
  parameter int   STALL_THRESH = 1024,
  parameter logic DIR          = DIR_PRODUCER
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear_stats,
  input  logic             tvalid,
  input  logic             tready,
  output logic             block,
  output logic             block_next,
  output logic [CNT_W-1:0] peak
);

  localparam logic [SAT_W-1:0] CNT_MAX = {SAT_W{1'b1}} >> (SAT_W - CNT_W);
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(STALL_THRESH);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc, peak_nx;
  logic             stall;

  // Producer stalls on back-pressure, consumer stalls on starvation.
  assign stall   = (DIR == DIR_PRODUCER) ? (tvalid & ~tready) : (tready & ~tvalid);
  assign cnt_inc = CNT_W'(saturating_inc(SAT_W'(cnt), CNT_MAX));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = RUN;
    cnt_nx   = '0;
    if (enable && stall) begin
      unique case (state)
        RUN: begin
          cnt_nx   = CNT_W'(1);
          state_nx = (STALL_THRESH == 1) ? BLOCKED : STALL;
        end
        STALL: begin
          cnt_nx   = cnt_inc;
          state_nx = (cnt_inc == THRESH) ? BLOCKED : STALL;
        end
        BLOCKED: begin
          cnt_nx   = cnt_inc;
          state_nx = BLOCKED;
        end
        default: begin
          cnt_nx   = '0;
          state_nx = RUN;
        end
      endcase
    end
  end

  assign block_next = (state_nx == BLOCKED);

  // Clear takes priority over a same-cycle peak update.
  always_comb begin
    peak_nx = peak;
    if (clear_stats)       peak_nx = '0;
    else if (cnt_nx > peak) peak_nx = cnt_nx;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= '0;
      block <= 1'b0;
      peak  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      block <= block_next;
      peak  <= peak_nx;
    end
  end

endmodule

// File: rtl/axis_block_detector.sv
// Per-channel AXI-Stream block flags for the deadlock monitors, plus peak-stall statistics.
// The top only replicates channels, registers the OR of the flags and packs the peaks.
module axis_block_detector
  import axis_block_pkg::*;
#(
  parameter int                NUM_CH       = 2,
  parameter int                CNT_W        = 16,
  parameter int                STALL_THRESH = 1024,
  parameter logic [NUM_CH-1:0] DIR_MASK     = 2'b10
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    clear_stats,
  input  logic [NUM_CH-1:0]       tvalid,
  input  logic [NUM_CH-1:0]       tready,
  output logic [NUM_CH-1:0]       axis_block_sigs,
  output logic                    block_any,
  output logic [NUM_CH*CNT_W-1:0] peak_stall
);

  logic [NUM_CH-1:0] block_next;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    axis_block_channel #(
      .CNT_W        (CNT_W),
      .STALL_THRESH (STALL_THRESH),
      .DIR          (DIR_MASK[i])
    ) u_ch (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (enable),
      .clear_stats (clear_stats),
      .tvalid      (tvalid[i]),
      .tready      (tready[i]),
      .block       (axis_block_sigs[i]),
      .block_next  (block_next[i]),
      .peak        (peak_stall[i*CNT_W +: CNT_W])
    );
  end

  // Built from next-state flags so it lines up with axis_block_sigs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) block_any <= 1'b0;
    else          block_any <= |block_next;
  end

endmodule

// File: tb/tb_axis_block_detector.sv
// Directed bench for axis_block_detector: three instances cover threshold 8,
// a narrow saturating counter (CNT_W=4, threshold 3) and threshold 1 with enable.
module tb_axis_block_detector;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  logic       en_a = 1'b1, clr_a = 1'b0;
  logic [1:0] tv_a = '0, tr_a = '0, sigs_a;
  logic       any_a;
  logic [31:0] peak_a;

  logic       en_b = 1'b1, clr_b = 1'b0;
  logic [1:0] tv_b = '0, tr_b = '0, sigs_b;
  logic       any_b;
  logic [7:0] peak_b;

  logic       en_c = 1'b1, clr_c = 1'b0;
  logic [1:0] tv_c = '0, tr_c = '0, sigs_c;
  logic       any_c;
  logic [31:0] peak_c;

  axis_block_detector #(.NUM_CH(2), .CNT_W(16), .STALL_THRESH(8), .DIR_MASK(2'b10)) dut_a (
    .clock(clock), .reset_n(reset_n), .enable(en_a), .clear_stats(clr_a),
    .tvalid(tv_a), .tready(tr_a), .axis_block_sigs(sigs_a), .block_any(any_a),
    .peak_stall(peak_a));

  axis_block_detector #(.NUM_CH(2), .CNT_W(4), .STALL_THRESH(3), .DIR_MASK(2'b10)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(en_b), .clear_stats(clr_b),
    .tvalid(tv_b), .tready(tr_b), .axis_block_sigs(sigs_b), .block_any(any_b),
    .peak_stall(peak_b));

  axis_block_detector #(.NUM_CH(2), .CNT_W(16), .STALL_THRESH(1), .DIR_MASK(2'b10)) dut_c (
    .clock(clock), .reset_n(reset_n), .enable(en_c), .clear_stats(clr_c),
    .tvalid(tv_c), .tready(tr_c), .axis_block_sigs(sigs_c), .block_any(any_c),
    .peak_stall(peak_c));

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2;
    check("a_reset_sigs", 32'(sigs_a), 32'h0);
    check("a_reset_any",  32'(any_a),  32'h0);
    check("a_reset_peak", peak_a,      32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Producer stall on ch1: tvalid=1, tready=0.
    tv_a = 2'b10; tr_a = 2'b00;
    tick(7);
    check("a_prod_7_sigs", 32'(sigs_a), 32'h0);
    tick(1);
    check("a_prod_8_sigs", 32'(sigs_a), 32'h2);
    check("a_prod_8_any",  32'(any_a),  32'h1);
    tick(3);
    check("a_prod_11_peak", peak_a, 32'h000B_0000);
    tr_a = 2'b10;
    tick(1);
    check("a_release_sigs", 32'(sigs_a), 32'h0);
    check("a_release_any",  32'(any_a),  32'h0);
    check("a_release_peak", peak_a, 32'h000B_0000);

    // Consumer near-miss on ch0: starved 7, one transfer, starved 7.
    tv_a = 2'b00; tr_a = 2'b01;
    tick(7);
    check("a_cons_7_sigs", 32'(sigs_a), 32'h0);
    tv_a = 2'b01;
    tick(1);
    tv_a = 2'b00;
    tick(7);
    check("a_cons_2nd_sigs", 32'(sigs_a), 32'h0);
    check("a_cons_any",      32'(any_a),  32'h0);
    check("a_cons_peak",     peak_a, 32'h000B_0007);

    // Clear versus peak update.
    tv_a = 2'b00; tr_a = 2'b00; clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("a_clear_idle_peak", peak_a, 32'h0);
    tr_a = 2'b01;
    tick(4);
    check("a_run4_peak", peak_a, 32'h0000_0004);
    clr_a = 1'b1;
    tick(1);
    check("a_clear_same_cycle", peak_a, 32'h0);
    clr_a = 1'b0;
    tick(1);
    check("a_after_clear_peak", peak_a, 32'h0000_0006);

    // Asynchronous reset while ch1 is blocked.
    tv_a = 2'b10; tr_a = 2'b00;
    tick(8);
    check("a_pre_reset_sigs", 32'(sigs_a), 32'h2);
    reset_n = 1'b0;
    #1;
    check("a_async_sigs", 32'(sigs_a), 32'h0);
    check("a_async_any",  32'(any_a),  32'h0);
    check("a_async_peak", peak_a, 32'h0);
    tv_a = 2'b00;
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Saturation: CNT_W=4, threshold 3, ch0 starved 40 cycles.
    tv_b = 2'b00; tr_b = 2'b01;
    tick(2);
    check("b_2_sigs", 32'(sigs_b), 32'h0);
    tick(1);
    check("b_3_sigs", 32'(sigs_b), 32'h1);
    check("b_3_any",  32'(any_b),  32'h1);
    tick(13);
    check("b_16_peak", 32'(peak_b), 32'h0F);
    tick(24);
    check("b_40_peak", 32'(peak_b), 32'h0F);
    check("b_40_sigs", 32'(sigs_b), 32'h1);
    tr_b = 2'b00;
    tick(1);
    check("b_release_sigs", 32'(sigs_b), 32'h0);

    // Threshold 1 and enable drop while blocked.
    tv_c = 2'b10; tr_c = 2'b00;
    tick(1);
    check("c_1_sigs", 32'(sigs_c), 32'h2);
    check("c_1_any",  32'(any_c),  32'h1);
    en_c = 1'b0;
    tick(1);
    check("c_dis_sigs", 32'(sigs_c), 32'h0);
    check("c_dis_any",  32'(any_c),  32'h0);
    check("c_dis_peak", peak_c, 32'h0001_0000);
    tick(3);
    check("c_dis_hold_sigs", 32'(sigs_c), 32'h0);
    en_c = 1'b1;
    tick(1);
    check("c_reen_sigs", 32'(sigs_c), 32'h2);
    check("c_reen_peak", peak_c, 32'h0001_0000);
    tick(2);
    check("c_reen_run_peak", peak_c, 32'h0003_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
